// File: rtl/io_irq_ctrl.sv
// io_irq_ctrl: four-channel external-byte interrupt controller with a CPU ack/strobe interface
//
// Ports:
//   clk                      single clock, rising edge
//   reset                    asynchronous, active-low
//   ext_valid[3:0]           source n offers a byte
//   ext_ready[3:0]           channel n is IDLE and can take a byte (combinational)
//   ext_data0..ext_data3     byte offered by source n
//   i1..i4                   last byte captured on channel n, presented to CPU port n+1
//   ie1..ie4                 registered interrupt request, high while channel n is ACTIVE
//   reg1_out..reg4_out       CPU output registers; reg4_out is the command port
//   out_stb[2:0]             one-cycle pulse when reg(j+1)_out changed
module io_irq_ctrl #(
  parameter int unsigned HOLDOFF = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ext_valid,
  output logic [3:0] ext_ready,
  input  logic [7:0] ext_data0,
  input  logic [7:0] ext_data1,
  input  logic [7:0] ext_data2,
  input  logic [7:0] ext_data3,
  output logic [7:0] i1,
  output logic [7:0] i2,
  output logic [7:0] i3,
  output logic [7:0] i4,
  output logic       ie1,
  output logic       ie2,
  output logic       ie3,
  output logic       ie4,
  input  logic [7:0] reg1_out,
  input  logic [7:0] reg2_out,
  input  logic [7:0] reg3_out,
  input  logic [7:0] reg4_out,
  output logic [2:0] out_stb
);
  typedef enum logic [1:0] {IDLE, FULL, ACTIVE, GAP} st_t;
  st_t        st_q   [4];
  logic [7:0] dat_q  [4];
  logic [3:0] cnt_q  [4];
  logic [7:0] prev_q [3];
  logic [3:0] ie_q;
  logic [2:0] stb_q;
  logic       cmd_prev_q;
  logic [7:0] ext_data [4];
  logic [7:0] regs [3];
  logic [3:0] full;
  logic [3:0] gnt;
  logic       ack;
  logic [1:0] ack_ch;
  logic       unused_cmd_bits;
  assign ext_data[0] = ext_data0;
  assign ext_data[1] = ext_data1;
  assign ext_data[2] = ext_data2;
  assign ext_data[3] = ext_data3;
  assign regs[0] = reg1_out;
  assign regs[1] = reg2_out;
  assign regs[2] = reg3_out;
  // A toggle of the command bit is the ack event; the low two bits name the channel.
  assign ack             = reg4_out[7] != cmd_prev_q;
  assign ack_ch          = reg4_out[1:0];
  assign unused_cmd_bits = ^reg4_out[6:2];
  always_comb begin
    full      = '0;
    ext_ready = '0;
    for (int n = 0; n < 4; n++) begin
      full[n]      = st_q[n] == FULL;
      ext_ready[n] = st_q[n] == IDLE;
    end
    // ie_q mirrors ACTIVE exactly, so it tells whether any channel is ACTIVE this cycle.
    // full & -full isolates the lowest-index FULL channel.
    gnt = (|ie_q) ? 4'b0000 : full & (~full + 4'd1);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < 4; n++) begin
        st_q[n]  <= IDLE;
        dat_q[n] <= 8'h00;
        cnt_q[n] <= 4'd0;
      end
      for (int j = 0; j < 3; j++) prev_q[j] <= 8'h00;
      ie_q       <= 4'b0000;
      stb_q      <= 3'b000;
      cmd_prev_q <= 1'b0;
    end else begin
      cmd_prev_q <= reg4_out[7];
      for (int j = 0; j < 3; j++) begin
        prev_q[j] <= regs[j];
        stb_q[j]  <= regs[j] != prev_q[j];
      end
      for (int n = 0; n < 4; n++) begin
        case (st_q[n])
          IDLE: if (ext_valid[n]) begin
            dat_q[n] <= ext_data[n];
            st_q[n]  <= FULL;
          end
          FULL: if (gnt[n]) begin
            st_q[n] <= ACTIVE;
            ie_q[n] <= 1'b1;
          end
          ACTIVE: if (ack && ack_ch == 2'(n)) begin
            st_q[n]  <= GAP;
            ie_q[n]  <= 1'b0;
            cnt_q[n] <= 4'(HOLDOFF - 1);
          end
          GAP: if (cnt_q[n] == 4'd0) st_q[n] <= IDLE;
               else cnt_q[n] <= cnt_q[n] - 4'd1;
          default: st_q[n] <= IDLE;
        endcase
      end
    end
  end
  assign i1      = dat_q[0];
  assign i2      = dat_q[1];
  assign i3      = dat_q[2];
  assign i4      = dat_q[3];
  assign ie1     = ie_q[0];
  assign ie2     = ie_q[1];
  assign ie3     = ie_q[2];
  assign ie4     = ie_q[3];
  assign out_stb = stb_q;
endmodule

// File: tb/tb_io_irq_ctrl.sv
// tb_io_irq_ctrl: scoreboard bench for io_irq_ctrl with directed scenarios and random traffic
module tb_io_irq_ctrl;
  localparam int HO = 2;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] ext_valid = '0;
  logic [3:0] ext_ready;
  logic [7:0] ext_d [4];
  logic [7:0] iv [4];
  logic       ie1, ie2, ie3, ie4;
  logic [7:0] reg_o [4];
  logic [2:0] out_stb;
  logic [3:0] ie_v;
  logic [3:0] ie_prev = '0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  assign ie_v = {ie4, ie3, ie2, ie1};
  always #5 clk = ~clk;
  io_irq_ctrl #(.HOLDOFF(HO)) dut (
    .clk(clk), .reset(reset), .ext_valid(ext_valid), .ext_ready(ext_ready),
    .ext_data0(ext_d[0]), .ext_data1(ext_d[1]), .ext_data2(ext_d[2]), .ext_data3(ext_d[3]),
    .i1(iv[0]), .i2(iv[1]), .i3(iv[2]), .i4(iv[3]),
    .ie1(ie1), .ie2(ie2), .ie3(ie3), .ie4(ie4),
    .reg1_out(reg_o[0]), .reg2_out(reg_o[1]), .reg3_out(reg_o[2]), .reg4_out(reg_o[3]),
    .out_stb(out_stb)
  );
  // Reference model: which channel holds the interrupt, which hold an unserved byte,
  // how many hold-off cycles remain, and the byte last captured per channel.
  int         m_act;
  bit         m_pend [4];
  int         m_gap [4];
  logic [7:0] m_i [4];
  bit         m_cmd;
  logic [7:0] m_prev [3];
  typedef struct { int ch; logic [7:0] d; int c; } irq_t;
  typedef struct { logic [2:0] s; int c; } stb_t;
  irq_t irq_q [$];
  stb_t stb_q [$];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask
  function automatic bit m_idle(int n);
    return !m_pend[n] && m_act != n && m_gap[n] == 0;
  endfunction
  function automatic logic [3:0] m_ready();
    logic [3:0] r = '0;
    for (int n = 0; n < 4; n++) r[n] = m_idle(n);
    return r;
  endfunction
  function automatic logic [3:0] m_ie();
    return m_act >= 0 ? 4'(1 << m_act) : 4'b0000;
  endfunction
  task automatic m_reset();
    m_act = -1;
    m_cmd = 1'b0;
    for (int n = 0; n < 4; n++) begin m_pend[n] = 0; m_gap[n] = 0; m_i[n] = 8'h00; end
    for (int j = 0; j < 3; j++) m_prev[j] = 8'h00;
    irq_q.delete();
    stb_q.delete();
  endtask
  // One clock edge of the model, using the inputs present at that edge.
  task automatic m_step();
    logic [3:0] rdy;
    logic [2:0] s;
    int act0;
    bit granted;
    rdy = m_ready();
    act0 = m_act;
    for (int n = 0; n < 4; n++) if (m_gap[n] > 0) m_gap[n]--;
    if (reg_o[3][7] != m_cmd && m_act == int'(reg_o[3][1:0])) begin
      m_gap[m_act] = HO;
      m_act = -1;
    end
    granted = 0;
    if (act0 < 0)
      for (int n = 0; n < 4; n++)
        if (!granted && m_pend[n]) begin
          granted = 1;
          m_pend[n] = 0;
          m_act = n;
          irq_q.push_back('{n, m_i[n], cyc});
        end
    for (int n = 0; n < 4; n++)
      if (rdy[n] && ext_valid[n]) begin m_pend[n] = 1; m_i[n] = ext_d[n]; end
    for (int j = 0; j < 3; j++) begin s[j] = reg_o[j] != m_prev[j]; m_prev[j] = reg_o[j]; end
    if (s != 3'b000) stb_q.push_back('{s, cyc});
    m_cmd = reg_o[3][7];
  endtask
  task automatic step();
    @(posedge clk);
    cyc++;
    if (reset) m_step();
    else m_reset();
    #1;
  endtask
  // Monitor: pops an expected event whenever the DUT raises an interrupt or a strobe.
  always @(negedge clk) begin
    logic [3:0] rise;
    irq_t e;
    stb_t s;
    rise = ie_v & ~ie_prev;
    ie_prev <= ie_v;
    if (rise != 4'b0000) begin
      if (irq_q.size() == 0) chk("irq_unexpected", 32'(rise), 32'h0);
      else begin
        e = irq_q.pop_front();
        chk("irq_channel", 32'(rise), 32'(1 << e.ch));
        chk("irq_cycle", cyc, e.c);
        chk("irq_byte", 32'(iv[e.ch]), 32'(e.d));
      end
    end else if (irq_q.size() > 0 && irq_q[0].c <= cyc) begin
      e = irq_q.pop_front();
      chk("irq_missing", 32'(rise), 32'(1 << e.ch));
    end
    if (out_stb != 3'b000) begin
      if (stb_q.size() == 0) chk("stb_unexpected", 32'(out_stb), 32'h0);
      else begin
        s = stb_q.pop_front();
        chk("stb_value", 32'(out_stb), 32'(s.s));
        chk("stb_cycle", cyc, s.c);
      end
    end else if (stb_q.size() > 0 && stb_q[0].c <= cyc) begin
      s = stb_q.pop_front();
      chk("stb_missing", 32'(out_stb), 32'(s.s));
    end
    chk("ext_ready", 32'(ext_ready), 32'(m_ready()));
    chk("ie_level", 32'(ie_v), 32'(m_ie()));
    for (int n = 0; n < 4; n++) chk("i_byte", 32'(iv[n]), 32'(m_i[n]));
  end
  initial begin
    logic [1:0] ch;
    for (int n = 0; n < 4; n++) begin ext_d[n] = 8'h00; reg_o[n] = 8'h00; end
    m_reset();
    #1;
    chk("reset_ready", 32'(ext_ready), 32'hF);
    chk("reset_ie", 32'(ie_v), 32'h0);
    step();
    reset = 1'b1;
    step();
    // Single interrupt round trip
    ext_valid = 4'b0001; ext_d[0] = 8'hA5;
    step();
    ext_valid = 4'b0000;
    chk("single_i1", 32'(iv[0]), 32'hA5);
    chk("single_ie_early", 32'(ie_v), 32'h0);
    step();
    chk("single_ie1", 32'(ie_v), 32'h1);
    reg_o[3] = 8'h80;
    step();
    chk("single_ie1_drop", 32'(ie_v), 32'h0);
    chk("single_gap_ready", 32'(ext_ready[0]), 32'h0);
    repeat (HO - 1) step();
    chk("single_gap_hold", 32'(ext_ready[0]), 32'h0);
    step();
    chk("single_ready_back", 32'(ext_ready[0]), 32'h1);
    // Priority between simultaneous captures
    ext_valid = 4'b0101; ext_d[0] = 8'h01; ext_d[2] = 8'h03;
    step();
    ext_valid = 4'b0000;
    step();
    chk("prio_first", 32'(ie_v), 32'h1);
    reg_o[3] = 8'h00;
    step();
    chk("prio_gapcycle", 32'(ie_v), 32'h0);
    step();
    chk("prio_second", 32'(ie_v), 32'h4);
    // Ack naming a channel that is not active
    reg_o[3] = 8'h83;
    step();
    chk("wrong_ack", 32'(ie_v), 32'h4);
    reg_o[3] = 8'h02;
    step();
    chk("right_ack", 32'(ie_v), 32'h0);
    repeat (HO + 1) step();
    // Backpressure on a FULL channel
    ext_valid = 4'b0011; ext_d[0] = 8'h77; ext_d[1] = 8'h11;
    step();
    ext_valid = 4'b0010; ext_d[1] = 8'h33;
    chk("bp_ready", 32'(ext_ready[1]), 32'h0);
    step();
    chk("bp_keep", 32'(iv[1]), 32'h11);
    ext_valid = 4'b0000;
    reg_o[3] = 8'h80;
    step();
    step();
    chk("bp_ie2", 32'(ie_v), 32'h2);
    chk("bp_keep2", 32'(iv[1]), 32'h11);
    reg_o[3] = 8'h01;
    step();
    repeat (HO) step();
    // Output strobes
    reg_o[1] = 8'h5A;
    step();
    chk("stb_pulse", 32'(out_stb), 32'h2);
    step();
    chk("stb_steady", 32'(out_stb), 32'h0);
    reg_o[3] = 8'h41;
    step();
    chk("stb_cmd_port", 32'(out_stb), 32'h0);
    // Reset in the middle of traffic
    ext_valid = 4'b0100; ext_d[2] = 8'hC3;
    step();
    ext_valid = 4'b0001; ext_d[0] = 8'h0F;
    step();
    ext_valid = 4'b0000;
    chk("rst_pre_ie3", 32'(ie_v), 32'h4);
    reset = 1'b0;
    m_reset();
    #1;
    chk("rst_ie", 32'(ie_v), 32'h0);
    chk("rst_i", 32'({iv[3], iv[2], iv[1], iv[0]}), 32'h0);
    chk("rst_stb", 32'(out_stb), 32'h0);
    step();
    reset = 1'b1;
    #1;
    chk("rst_rel_ready", 32'(ext_ready), 32'hF);
    chk("rst_rel_ie", 32'(ie_v), 32'h0);
    chk("rst_rel_stb", 32'(out_stb), 32'h0);
    step();
    chk("rst_after_ie", 32'(ie_v), 32'h0);
    // Random traffic
    for (int t = 0; t < 3000; t++) begin
      ext_valid = 4'($urandom);
      for (int n = 0; n < 4; n++) ext_d[n] = 8'($urandom);
      for (int j = 0; j < 3; j++) if ($urandom_range(0, 3) == 0) reg_o[j] = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        ch = (m_act >= 0 && $urandom_range(0, 3) != 0) ? 2'(m_act) : 2'($urandom);
        reg_o[3] = {~reg_o[3][7], 5'($urandom), ch};
      end else reg_o[3][6:0] = 7'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b0;
        m_reset();
        step();
        reset = 1'b1;
      end
      step();
    end
    ext_valid = 4'b0000;
    repeat (4) step();
    chk("irq_queue_drained", irq_q.size(), 0);
    chk("stb_queue_drained", stb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
